// File: rtl/counter_run_arbiter_if.sv
// Request/grant bundle between soft-logic clients and the shared interval counter.
// The client side (master) drives requests and abort; the arbiter (slave) drives
// the accept/done pulses and the live counter status.
interface counter_run_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32,
  parameter int EVT_W   = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       wReqValid;
  logic [NUM_REQ*CNT_W-1:0] wReqCompare;
  logic                     wAbort;
  logic [NUM_REQ-1:0]       rReqReady;
  logic [NUM_REQ-1:0]       rDone;
  logic                     rBusy;
  logic [ID_W-1:0]          rGrantId;
  logic [CNT_W-1:0]         rCount;
  logic [EVT_W-1:0]         rEvtCount;

  modport master (
    output wReqValid, wReqCompare, wAbort,
    input  rReqReady, rDone, rBusy, rGrantId, rCount, rEvtCount
  );

  modport slave (
    input  wReqValid, wReqCompare, wAbort,
    output rReqReady, rDone, rBusy, rGrantId, rCount, rEvtCount
  );
endinterface

// File: rtl/counter_run_arbiter.sv
// Shares one interval counter between NUM_REQ requesters. A round-robin pick in
// IDLE grants the counter to one requester, RUN counts up to its compare value,
// and DONE pulses that requester's done line and bumps the completed-run count.
module counter_run_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32,
  parameter int EVT_W   = 8
) (
  input  logic                 wClk,
  input  logic                 wRstN,
  counter_run_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rrPtr;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  scanIdx;
  logic             anyReq;
  logic             lastCycle;
  logic [CNT_W-1:0] cmpLatch;
  logic [CNT_W-1:0] pickCmp;

  // Next requester index, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] wrapInc(input logic [ID_W-1:0] v);
    return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + ID_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] oneHot(input logic [ID_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Round-robin search: first valid request at or after the pointer, wrapping.
  always_comb begin
    anyReq  = 1'b0;
    pick    = rrPtr;
    scanIdx = rrPtr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!anyReq && bus.wReqValid[scanIdx]) begin
        anyReq = 1'b1;
        pick   = scanIdx;
      end
      scanIdx = wrapInc(scanIdx);
    end
  end

  // Compare value of the requester being picked this cycle.
  always_comb begin
    pickCmp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) pickCmp = bus.wReqCompare[i*CNT_W +: CNT_W];
    end
  end

  // Final RUN cycle: a compare of 0 or 1 still gives exactly one RUN cycle.
  always_comb begin
    lastCycle = (cmpLatch <= CNT_W'(1)) || (bus.rCount == cmpLatch - CNT_W'(1));
  end

  // Grant/run/done controller with all outputs registered.
  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN) begin
      state         <= IDLE;
      rrPtr         <= '0;
      cmpLatch      <= '0;
      bus.rReqReady <= '0;
      bus.rDone     <= '0;
      bus.rBusy     <= 1'b0;
      bus.rGrantId  <= '0;
      bus.rCount    <= '0;
      bus.rEvtCount <= '0;
    end else begin
      bus.rReqReady <= '0;
      bus.rDone     <= '0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            cmpLatch      <= pickCmp;
            bus.rGrantId  <= pick;
            rrPtr         <= wrapInc(pick);
            bus.rReqReady <= oneHot(pick);
            bus.rCount    <= '0;
            bus.rBusy     <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          // Abort wins over completion in the same cycle.
          if (bus.wAbort) begin
            bus.rCount <= '0;
            bus.rBusy  <= 1'b0;
            state      <= IDLE;
          end else if (lastCycle) begin
            bus.rDone     <= oneHot(bus.rGrantId);
            bus.rEvtCount <= bus.rEvtCount + EVT_W'(1);
            state         <= DONE;
          end else begin
            bus.rCount <= bus.rCount + CNT_W'(1);
          end
        end
        DONE: begin
          bus.rCount <= '0;
          bus.rBusy  <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.rCount <= '0;
          bus.rBusy  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule
